// File: rtl/game_flow_controller_if.sv
// Game flow bus: button and gameplay event pulses toward the controller, plus the
// registered game status it drives into the renderer.
//   slave  : the controller (consumes pulses, drives status)
//   master : the stimulus side (buttons, physics/collision block, renderer)
// Clock and reset are not part of the bus.
interface game_flow_controller_if;
    logic       frame_tick;
    logic       btn_up;
    logic       btn_down;
    logic       btn_select;
    logic       btn_back;
    logic       hit_evt;
    logic       collect_evt;
    logic       deposit_evt;
    logic [1:0] game_state;
    logic       menu_selection;
    logic [1:0] current_hp;
    logic [7:0] bank_level;
    logic [2:0] held_count;
    logic [9:0] player_height;
    logic       invuln;
    logic       round_start;
    logic       paused;

    modport slave (
        input  frame_tick, btn_up, btn_down, btn_select, btn_back,
        input  hit_evt, collect_evt, deposit_evt,
        output game_state, menu_selection, current_hp, bank_level, held_count,
        output player_height, invuln, round_start, paused
    );

    modport master (
        output frame_tick, btn_up, btn_down, btn_select, btn_back,
        output hit_evt, collect_evt, deposit_evt,
        input  game_state, menu_selection, current_hp, bank_level, held_count,
        input  player_height, invuln, round_start, paused
    );
endinterface

// File: rtl/game_flow_controller.sv
// Game flow controller: owns the game FSM (START / PLAYING / INSTRUCTIONS / GAME_OVER),
// the menu highlight, lives, banked score, held-box count, player stack height and
// post-hit immunity counter. All outputs are registered.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset
//   bus  - game_flow_controller_if.slave: button/event pulses in, game status out
// Optional feature macro GAME_FLOW_PAUSE_EN: btn_back toggles pause in PLAYING; while
// paused, gameplay events are ignored and the immunity counter is frozen. Without the
// macro, paused stays 0 and btn_back is ignored in PLAYING.
module game_flow_controller #(
    parameter logic [1:0] MAX_HP          = 2'd3,
    parameter logic [2:0] MAX_HELD        = 3'd4,
    parameter logic [9:0] BOX_BASE_HEIGHT = 10'd30,
    parameter logic [7:0] INVULN_FRAMES   = 8'd60
) (
    input logic              clk,
    input logic              rst,
    game_flow_controller_if.slave bus
);

    typedef enum logic [1:0] {
        StStart    = 2'b00,
        StPlaying  = 2'b01,
        StInstr    = 2'b10,
        StGameOver = 2'b11
    } state_e;

    state_e     state_q, state_d;
    logic       sel_q, sel_d;
    logic [1:0] hp_q, hp_d;
    logic [7:0] bank_q, bank_d;
    logic [2:0] held_q, held_d;
    logic [9:0] height_q, height_d;
    logic [7:0] cnt_q, cnt_d;
    logic       invuln_q, invuln_d;
    logic       round_start_q, round_start_d;
    logic       paused_q, paused_d;

    logic       active;
    logic [2:0] held_tmp;
    logic [8:0] bank_sum;

    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        hp_d          = hp_q;
        bank_d        = bank_q;
        held_d        = held_q;
        cnt_d         = cnt_q;
        round_start_d = 1'b0;
        paused_d      = paused_q;
        active        = 1'b1;
        held_tmp      = held_q;
        bank_sum      = {1'b0, bank_q} + {6'd0, held_q};

        unique case (state_q)
            StStart: begin
                // Conflicting up/down in one cycle leave the highlight alone.
                if (bus.btn_up && !bus.btn_down) begin
                    sel_d = 1'b0;
                end else if (bus.btn_down && !bus.btn_up) begin
                    sel_d = 1'b1;
                end
                if (bus.btn_select) begin
                    if (!sel_q) begin
                        state_d       = StPlaying;
                        hp_d          = MAX_HP;
                        bank_d        = 8'd0;
                        held_d        = 3'd0;
                        cnt_d         = 8'd0;
                        round_start_d = 1'b1;
                        paused_d      = 1'b0;
                    end else begin
                        state_d = StInstr;
                    end
                end
            end

            StInstr: begin
                if (bus.btn_select || bus.btn_back) begin
                    state_d = StStart;
                end
            end

            StGameOver: begin
                // Score and hp stay visible until the next game is started.
                if (bus.btn_select) begin
                    state_d = StStart;
                    sel_d   = 1'b0;
                end
            end

            StPlaying: begin
`ifdef GAME_FLOW_PAUSE_EN
                if (bus.btn_back) begin
                    paused_d = !paused_q;
                end
                active = !paused_q;
`else
                paused_d = 1'b0;
`endif
                if (active) begin
                    if (bus.hit_evt && (cnt_q == 8'd0)) begin
                        // Effective hit wins over collect/deposit and swallows frame_tick.
                        hp_d   = hp_q - 2'd1;
                        held_d = 3'd0;
                        if (hp_d == 2'd0) begin
                            state_d  = StGameOver;
                            cnt_d    = 8'd0;
                            paused_d = 1'b0;
                        end else begin
                            cnt_d = INVULN_FRAMES;
                        end
                    end else begin
                        // Deposit first, then collect into the emptied hands.
                        if (bus.deposit_evt) begin
                            bank_d   = bank_sum[8] ? 8'hff : bank_sum[7:0];
                            held_tmp = 3'd0;
                        end
                        if (bus.collect_evt && (held_tmp < MAX_HELD)) begin
                            held_tmp = held_tmp + 3'd1;
                        end
                        held_d = held_tmp;
                        if (bus.frame_tick && (cnt_q != 8'd0)) begin
                            cnt_d = cnt_q - 8'd1;
                        end
                    end
                end
            end

            default: state_d = StStart;
        endcase

        height_d = BOX_BASE_HEIGHT * ({7'd0, held_d} + 10'd1);
        invuln_d = (cnt_d != 8'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StStart;
            sel_q         <= 1'b0;
            hp_q          <= MAX_HP;
            bank_q        <= 8'd0;
            held_q        <= 3'd0;
            height_q      <= BOX_BASE_HEIGHT;
            cnt_q         <= 8'd0;
            invuln_q      <= 1'b0;
            round_start_q <= 1'b0;
            paused_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            hp_q          <= hp_d;
            bank_q        <= bank_d;
            held_q        <= held_d;
            height_q      <= height_d;
            cnt_q         <= cnt_d;
            invuln_q      <= invuln_d;
            round_start_q <= round_start_d;
            paused_q      <= paused_d;
        end
    end

    assign bus.game_state     = state_q;
    assign bus.menu_selection = sel_q;
    assign bus.current_hp     = hp_q;
    assign bus.bank_level     = bank_q;
    assign bus.held_count     = held_q;
    assign bus.player_height  = height_q;
    assign bus.invuln         = invuln_q;
    assign bus.round_start    = round_start_q;
    assign bus.paused         = paused_q;

endmodule
